// File: rtl/logicop_resp_checker.sv
// ---------------------------------------------------------------------------
// logicop_resp_checker
//
// Response checker for the 4-bit logical-operator unit
// (res1 = !in1, res2 = in1 && in2, res3 = in1 || in2). It consumes one
// operand/result tuple per valid/ready handshake. For each tuple it recomputes
// the expected results in a two-stage pipeline and keeps saturating pass/fail
// counts, a sticky error flag and the first failing vector.
//
// Optional feature macro: LOGICOP_CHK_FAILCAP_EN
//   defined     -> first-fail capture registers (fail_idx/fail_in1/fail_in2)
//   not defined -> capture omitted, those outputs tied to 0
//
// Ports:
//   clk_i                rising-edge clock
//   rst_ni               asynchronous active-low reset (2-flop synchronised release)
//   start_i              single-cycle pulse: clear all state and begin a run
//   s_valid_i/s_ready_o  tuple handshake
//   in1_i, in2_i         operands applied to the unit under check
//   res1_i..res3_i       results produced by the unit under check
//   pass_cnt_o/fail_cnt_o  saturating counts of matching/mismatching vectors
//   err_o                sticky flag, set on the first mismatch of a run
//   busy_o / done_o      run in progress / run complete (held until start)
//   fail_idx_o           0-based index of the first failing vector
//   fail_in1_o/fail_in2_o  operands of the first failing vector
// ---------------------------------------------------------------------------
module logicop_resp_checker #(
  parameter int WIDTH   = 4,
  parameter int NUM_VEC = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] fail_idx_o,
  output logic [WIDTH-1:0] fail_in1_o,
  output logic [WIDTH-1:0] fail_in2_o
);

  // The accept counter is sized from NUM_VEC, not CNT_W, so a narrow
  // counter width never limits the run length.
  localparam int ACC_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         rstSync_q;
  logic               rstInt_n;
  logic [ACC_W-1:0]   accCnt_q, accCnt_d;
  logic               accept;
  logic               s1Valid_q;
  logic [WIDTH-1:0]   s1Exp1_q, s1Exp2_q, s1Exp3_q;
  logic [WIDTH-1:0]   s1Res1_q, s1Res2_q, s1Res3_q;
  logic               mismatch;
  logic [CNT_W-1:0]   passCnt_q, failCnt_q;
  logic               err_q;

  // Reset assertion is immediate; release is delayed by two clock edges so
  // every register leaves reset on the same, clean edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rstSync_q <= 2'b00;
    else         rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n = rstSync_q[1];

  // Start wins over a same-cycle tuple, so accept is masked by start_i.
  assign accept = s_valid_i && (state_q == RUN) && !start_i;

  // Next-state logic: start restarts from any state; the last accept moves
  // to DRAIN so the final compare can retire before DONE.
  always_comb begin
    state_d  = state_q;
    accCnt_d = accCnt_q;
    if (start_i) begin
      state_d  = RUN;
      accCnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            accCnt_d = accCnt_q + ACC_W'(1);
            if (accCnt_q == ACC_W'(NUM_VEC - 1)) state_d = DRAIN;
          end
        end
        DRAIN:   state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM state and accept counter registers.
  always_ff @(posedge clk_i or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q  <= IDLE;
      accCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      accCnt_q <= accCnt_d;
    end
  end

  // Stage 1: register expected values (zero-extended booleans) and the
  // results. A start drops any entry in flight so it is never counted.
  always_ff @(posedge clk_i or negedge rstInt_n) begin
    if (!rstInt_n) begin
      s1Valid_q <= 1'b0;
      s1Exp1_q  <= '0;
      s1Exp2_q  <= '0;
      s1Exp3_q  <= '0;
      s1Res1_q  <= '0;
      s1Res2_q  <= '0;
      s1Res3_q  <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        s1Exp1_q <= WIDTH'(in1_i == '0);
        s1Exp2_q <= WIDTH'((in1_i != '0) && (in2_i != '0));
        s1Exp3_q <= WIDTH'((in1_i != '0) || (in2_i != '0));
        s1Res1_q <= res1_i;
        s1Res2_q <= res2_i;
        s1Res3_q <= res3_i;
      end
    end
  end

  assign mismatch = (s1Res1_q != s1Exp1_q) || (s1Res2_q != s1Exp2_q) ||
                    (s1Res3_q != s1Exp3_q);

  // Stage 2: exactly one saturating counter steps per retired entry.
  always_ff @(posedge clk_i or negedge rstInt_n) begin
    if (!rstInt_n) begin
      passCnt_q <= '0;
      failCnt_q <= '0;
      err_q     <= 1'b0;
    end else if (start_i) begin
      passCnt_q <= '0;
      failCnt_q <= '0;
      err_q     <= 1'b0;
    end else if (s1Valid_q) begin
      if (mismatch) begin
        err_q <= 1'b1;
        if (failCnt_q != {CNT_W{1'b1}}) failCnt_q <= failCnt_q + CNT_W'(1);
      end else begin
        if (passCnt_q != {CNT_W{1'b1}}) passCnt_q <= passCnt_q + CNT_W'(1);
      end
    end
  end

`ifdef LOGICOP_CHK_FAILCAP_EN
  logic [WIDTH-1:0] s1In1_q, s1In2_q;
  logic [ACC_W-1:0] s1Idx_q;
  logic [CNT_W-1:0] failIdx_q;
  logic [WIDTH-1:0] failIn1_q, failIn2_q;

  // Operands and index travel alongside stage 1 only when capture is built.
  always_ff @(posedge clk_i or negedge rstInt_n) begin
    if (!rstInt_n) begin
      s1In1_q <= '0;
      s1In2_q <= '0;
      s1Idx_q <= '0;
    end else if (accept) begin
      s1In1_q <= in1_i;
      s1In2_q <= in2_i;
      s1Idx_q <= accCnt_q;
    end
  end

  // First-fail capture: loads only while err is still clear in this run.
  always_ff @(posedge clk_i or negedge rstInt_n) begin
    if (!rstInt_n) begin
      failIdx_q <= '0;
      failIn1_q <= '0;
      failIn2_q <= '0;
    end else if (start_i) begin
      failIdx_q <= '0;
      failIn1_q <= '0;
      failIn2_q <= '0;
    end else if (s1Valid_q && mismatch && !err_q) begin
      failIdx_q <= CNT_W'(s1Idx_q);
      failIn1_q <= s1In1_q;
      failIn2_q <= s1In2_q;
    end
  end

  assign fail_idx_o = failIdx_q;
  assign fail_in1_o = failIn1_q;
  assign fail_in2_o = failIn2_q;
`else
  assign fail_idx_o = '0;
  assign fail_in1_o = '0;
  assign fail_in2_o = '0;
`endif

  assign s_ready_o  = (state_q == RUN);
  assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign pass_cnt_o = passCnt_q;
  assign fail_cnt_o = failCnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_logicop_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_logicop_resp_checker
//
// Directed, table-driven bench for logicop_resp_checker. A CNT_W=8 checker
// and a CNT_W=2 checker share the same stimulus; the narrow one shows the
// saturating pass counter. Expected first-fail capture values depend on
// whether LOGICOP_CHK_FAILCAP_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_logicop_resp_checker;

`ifdef LOGICOP_CHK_FAILCAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sValid;
  logic [3:0] in1, in2, res1, res2, res3;

  logic       sReady,  busy,  done,  err;
  logic [7:0] passCnt, failCnt, failIdx;
  logic [3:0] failIn1, failIn2;

  logic       sReadyN, busyN, doneN, errN;
  logic [1:0] passCntN, failCntN, failIdxN;
  logic [3:0] failIn1N, failIn2N;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [3:0] in1, in2, res1, res2, res3;
    int         expPass;
    int         expFail;
    logic       expErr;
  } vec_t;

  vec_t vecTab[12];

  logicop_resp_checker #(.WIDTH(4), .NUM_VEC(6), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .s_valid_i(sValid),
    .s_ready_o(sReady), .in1_i(in1), .in2_i(in2), .res1_i(res1),
    .res2_i(res2), .res3_i(res3), .pass_cnt_o(passCnt), .fail_cnt_o(failCnt),
    .err_o(err), .busy_o(busy), .done_o(done), .fail_idx_o(failIdx),
    .fail_in1_o(failIn1), .fail_in2_o(failIn2)
  );

  logicop_resp_checker #(.WIDTH(4), .NUM_VEC(6), .CNT_W(2)) dutNarrow (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .s_valid_i(sValid),
    .s_ready_o(sReadyN), .in1_i(in1), .in2_i(in2), .res1_i(res1),
    .res2_i(res2), .res3_i(res3), .pass_cnt_o(passCntN), .fail_cnt_o(failCntN),
    .err_o(errN), .busy_o(busyN), .done_o(doneN), .fail_idx_o(failIdxN),
    .fail_in1_o(failIn1N), .fail_in2_o(failIn2N)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] r1, input logic [3:0] r2,
                               input logic [3:0] r3, input logic v);
    in1    = a;
    in2    = b;
    res1   = r1;
    res2   = r2;
    res3   = r3;
    sValid = v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  // Back-to-back run of six table entries; counters are checked one cycle
  // behind the accept that produced them.
  task automatic runTable(input int base);
    vec_t v;
    for (int i = 0; i < 6; i++) begin
      v = vecTab[base + i];
      applyStimulus(v.in1, v.in2, v.res1, v.res2, v.res3, 1'b1);
      stepCycle();
      checkOutput("s_ready after accept", 32'(sReady), 32'(i < 5));
      checkOutput("busy during run", 32'(busy), 32'd1);
      checkOutput("done during run", 32'(done), 32'd0);
      if (i > 0) begin
        checkOutput("pass_cnt pipelined", 32'(passCnt), 32'(vecTab[base + i - 1].expPass));
        checkOutput("fail_cnt pipelined", 32'(failCnt), 32'(vecTab[base + i - 1].expFail));
        checkOutput("err pipelined", 32'(err), 32'(vecTab[base + i - 1].expErr));
      end
    end
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    stepCycle();
    checkOutput("final pass_cnt", 32'(passCnt), 32'(vecTab[base + 5].expPass));
    checkOutput("final fail_cnt", 32'(failCnt), 32'(vecTab[base + 5].expFail));
    checkOutput("final err", 32'(err), 32'(vecTab[base + 5].expErr));
    checkOutput("done after drain", 32'(done), 32'd1);
    checkOutput("busy after drain", 32'(busy), 32'd0);
    checkOutput("s_ready in done", 32'(sReady), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " s_ready"}, 32'(sReady), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkOutput({tag, " pass_cnt"}, 32'(passCnt), 32'd0);
    checkOutput({tag, " fail_cnt"}, 32'(failCnt), 32'd0);
    checkOutput({tag, " fail_idx"}, 32'(failIdx), 32'd0);
    checkOutput({tag, " fail_in1"}, 32'(failIn1), 32'd0);
    checkOutput({tag, " fail_in2"}, 32'(failIn2), 32'd0);
  endtask

  initial begin
    int accepted;
    logic modelReady;
    logic modelAccept;
    vec_t v;

    // All-correct run: results are the true logical-operator outputs.
    vecTab[0] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0, 1'b0};
    vecTab[1] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2, 0, 1'b0};
    vecTab[2] = '{4'b1010, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 3, 0, 1'b0};
    vecTab[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4, 0, 1'b0};
    vecTab[4] = '{4'b0001, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 5, 0, 1'b0};
    vecTab[5] = '{4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0001, 6, 0, 1'b0};
    // Faulty run: vector 2 res2 and vector 4 res3 forced to 0000.
    vecTab[6]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0, 1'b0};
    vecTab[7]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2, 0, 1'b0};
    vecTab[8]  = '{4'b1010, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 2, 1, 1'b1};
    vecTab[9]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 3, 1, 1'b1};
    vecTab[10] = '{4'b0001, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 3, 2, 1'b1};
    vecTab[11] = '{4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0001, 4, 2, 1'b1};

    start = 1'b0;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checkResetValues("reset");
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    repeat (3) stepCycle();

    // Scenario 1: all vectors correct; narrow counter saturates at 3.
    $display("[TB] all-pass run");
    pulseStart();
    checkOutput("s_ready after start", 32'(sReady), 32'd1);
    checkOutput("busy after start", 32'(busy), 32'd1);
    runTable(0);
    checkOutput("narrow pass_cnt saturates", 32'(passCntN), 32'd3);
    checkOutput("narrow fail_cnt", 32'(failCntN), 32'd0);
    checkOutput("narrow done", 32'(doneN), 32'd1);

    // Scenario 2: two faulty vectors, first failure captured.
    $display("[TB] faulty run");
    pulseStart();
    checkOutput("counters cleared by start", 32'(passCnt), 32'd0);
    checkOutput("done cleared by start", 32'(done), 32'd0);
    runTable(6);
    checkOutput("fail_idx", 32'(failIdx), CAP_EN ? 32'd2 : 32'd0);
    checkOutput("fail_in1", 32'(failIn1), CAP_EN ? 32'b1010 : 32'd0);
    checkOutput("fail_in2", 32'(failIn2), CAP_EN ? 32'b0101 : 32'd0);
    checkOutput("narrow pass_cnt saturates", 32'(passCntN), 32'd3);
    checkOutput("narrow fail_cnt", 32'(failCntN), 32'd2);

    // Scenario 3: valid toggles every cycle; the 7th valid is ignored.
    $display("[TB] toggling valid");
    pulseStart();
    accepted   = 0;
    modelReady = 1'b1;
    for (int k = 0; k < 14; k++) begin
      v = vecTab[accepted % 6];
      applyStimulus(v.in1, v.in2, v.res1, v.res2, v.res3, (k % 2) == 0);
      modelAccept = ((k % 2) == 0) && modelReady;
      stepCycle();
      if (modelAccept) accepted++;
      modelReady = (accepted < 6);
      checkOutput("toggle s_ready", 32'(sReady), 32'(modelReady));
    end
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("toggle pass_cnt", 32'(passCnt), 32'd6);
    checkOutput("toggle fail_cnt", 32'(failCnt), 32'd0);
    checkOutput("toggle done", 32'(done), 32'd1);

    // Scenario 4: start after three accepts aborts; failing entry in flight
    // is discarded.
    $display("[TB] abort by start");
    pulseStart();
    for (int i = 0; i < 3; i++) begin
      v = vecTab[6 + i];
      applyStimulus(v.in1, v.in2, v.res1, v.res2, v.res3, 1'b1);
      stepCycle();
    end
    pulseStart();
    checkOutput("abort pass_cnt", 32'(passCnt), 32'd0);
    checkOutput("abort fail_cnt", 32'(failCnt), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd1);
    checkOutput("abort s_ready", 32'(sReady), 32'd1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    stepCycle();
    checkOutput("in-flight discarded fail_cnt", 32'(failCnt), 32'd0);
    checkOutput("in-flight discarded err", 32'(err), 32'd0);
    checkOutput("in-flight discarded pass_cnt", 32'(passCnt), 32'd0);
    runTable(0);

    // Scenario 5: one-cycle reset pulse mid-run.
    $display("[TB] reset mid-run");
    pulseStart();
    for (int i = 0; i < 3; i++) begin
      v = vecTab[6 + i];
      applyStimulus(v.in1, v.in2, v.res1, v.res2, v.res3, 1'b1);
      stepCycle();
    end
    rst_n = 1'b0;
    #2;
    checkResetValues("async reset");
    stepCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = vecTab[i % 6];
      applyStimulus(v.in1, v.in2, v.res1, v.res2, v.res3, 1'b1);
      stepCycle();
    end
    checkOutput("post-reset done", 32'(done), 32'd0);
    checkOutput("post-reset s_ready", 32'(sReady), 32'd0);
    checkOutput("post-reset pass_cnt", 32'(passCnt), 32'd0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    pulseStart();
    runTable(6);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
